// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter sharing one small ALU between two requesters
module alu_share_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [1:0] req0_sel,
  input  logic [2:0] req0_a,
  input  logic [2:0] req0_b,
  output logic       req0_ready,
  output logic       rsp0_valid,
  output logic [5:0] rsp0_data,
  input  logic       rsp0_ack,
  input  logic       req1_valid,
  input  logic [1:0] req1_sel,
  input  logic [2:0] req1_a,
  input  logic [2:0] req1_b,
  output logic       req1_ready,
  output logic       rsp1_valid,
  output logic [5:0] rsp1_data,
  input  logic       rsp1_ack,
  output logic       busy,
  output logic [7:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d, gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [2:0] a_q, a_d, b_q, b_d;
  logic [5:0] res_q, res_d;
  logic [7:0] cnt_q, cnt_d;
  logic g0, g1, ack;
  always_comb begin
    g0 = req0_valid && (!req1_valid || !ptr_q);
    g1 = req1_valid && (!req0_valid || ptr_q);
    ack = gnt_q ? rsp1_ack : rsp0_ack;
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    sel_d = sel_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (g0 || g1) begin
        state_d = EXEC;
        gnt_d = g1;
        sel_d = g1 ? req1_sel : req0_sel;
        a_d = g1 ? req1_a : req0_a;
        b_d = g1 ? req1_b : req0_b;
      end
      EXEC: begin
        state_d = RESP;
        res_d = sel_q == 2'b00 ? {3'b000, a_q & b_q} :
                sel_q == 2'b01 ? {3'b000, a_q} * {3'b000, b_q} :
                sel_q == 2'b10 ? {3'b000, ~(a_q & b_q)} :
                                 {3'b000, a_q ^ b_q};
      end
      RESP: if (ack) begin
        state_d = IDLE;
        ptr_d = !gnt_q;
        cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
    req0_ready = state_q == IDLE && !rst && g0;
    req1_ready = state_q == IDLE && !rst && g1;
    rsp0_valid = state_q == RESP && !gnt_q;
    rsp1_valid = state_q == RESP && gnt_q;
    rsp0_data = rsp0_valid ? res_q : 6'd0;
    rsp1_data = rsp1_valid ? res_q : 6'd0;
    busy = state_q != IDLE;
    op_count = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      gnt_q <= 1'b0;
      sel_q <= 2'd0;
      a_q <= 3'd0;
      b_q <= 3'd0;
      res_q <= 6'd0;
      cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed scenario tests for alu_share_ctrl
module tb_alu_share_ctrl;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, rsp0_ack = 0, rsp1_ack = 0;
  logic [1:0] req0_sel = 0, req1_sel = 0;
  logic [2:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [5:0] rsp0_data, rsp1_data;
  logic [7:0] op_count;
  int vectors = 0, errors = 0;

  alu_share_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ack(rsp0_ack),
    .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ack(rsp1_ack),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    req0_valid = 1;
    req1_valid = 1;
    rst = 1;
    tick();
    tick();
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
    vectors++;
    if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin errors++; $display("FAIL reset_rsp got %b want 000", {rsp0_valid, rsp1_valid, busy}); end
    vectors++;
    if ({rsp0_data, rsp1_data} !== 12'd0 || op_count !== 8'd0) begin errors++; $display("FAIL reset_data got %h/%h cnt %0d want 0", rsp0_data, rsp1_data, op_count); end
    req0_valid = 0;
    req1_valid = 0;
    rst = 0;
  endtask

  task automatic test_single;
    req0_valid = 1; req0_sel = 2'b01; req0_a = 7; req0_b = 7;
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 0;
    #1;
    vectors++;
    if ({busy, req0_ready, rsp0_valid} !== 3'b100) begin errors++; $display("FAIL single_exec got %b want 100", {busy, req0_ready, rsp0_valid}); end
    tick();
    #1;
    vectors++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 6'd49) begin errors++; $display("FAIL single_rsp got v=%b d=%0d want v=1 d=49", rsp0_valid, rsp0_data); end
    vectors++;
    if (rsp1_valid !== 1'b0 || rsp1_data !== 6'd0) begin errors++; $display("FAIL single_other got v=%b d=%0d want 0", rsp1_valid, rsp1_data); end
    rsp0_ack = 1;
    tick();
    rsp0_ack = 0;
    #1;
    vectors++;
    if (op_count !== 8'd1 || busy !== 1'b0) begin errors++; $display("FAIL single_count got cnt=%0d busy=%b want 1/0", op_count, busy); end
  endtask

  task automatic test_opcodes;
    logic [1:0] sels [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [5:0] exps [4] = '{6'b000001, 6'b000110, 6'b000110, 6'b001111};
    for (int i = 0; i < 4; i++) begin
      req1_valid = 1; req1_sel = sels[i]; req1_a = 3'b101; req1_b = 3'b011;
      tick();
      req1_valid = 0;
      tick();
      #1;
      vectors++;
      if (rsp1_valid !== 1'b1 || rsp1_data !== exps[i]) begin errors++; $display("FAIL opcode sel=%b got v=%b d=%b want v=1 d=%b", sels[i], rsp1_valid, rsp1_data, exps[i]); end
      rsp1_ack = 1;
      tick();
      rsp1_ack = 0;
    end
    vectors++;
    if (op_count !== 8'd5) begin errors++; $display("FAIL opcode_count got %0d want 5", op_count); end
  endtask

  task automatic test_contention;
    logic g;
    do_reset();
    req0_valid = 1; req0_sel = 2'b11; req0_a = 1; req0_b = 2;
    req1_valid = 1; req1_sel = 2'b00; req1_a = 7; req1_b = 5;
    for (int i = 0; i < 4; i++) begin
      g = (i % 2) == 1;
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contention_grant op%0d got r1r0=%b want grant %0d", i, {req1_ready, req0_ready}, g); end
      tick();
      tick();
      #1;
      vectors++;
      if ({rsp1_valid, rsp0_valid} !== (g ? 2'b10 : 2'b01) || (g ? rsp1_data : rsp0_data) !== (g ? 6'd5 : 6'd3)) begin
        errors++; $display("FAIL contention_rsp op%0d got v=%b d0=%0d d1=%0d", i, {rsp1_valid, rsp0_valid}, rsp0_data, rsp1_data);
      end
      if (g) rsp0_ack = 1; else rsp1_ack = 1;
      tick();
      #1;
      vectors++;
      if (busy !== 1'b1 || op_count !== 8'(i)) begin errors++; $display("FAIL contention_wrong_ack op%0d got busy=%b cnt=%0d want 1/%0d", i, busy, op_count, i); end
      rsp0_ack = !g; rsp1_ack = g;
      tick();
      rsp0_ack = 0; rsp1_ack = 0;
    end
    #1;
    vectors++;
    if (op_count !== 8'd4) begin errors++; $display("FAIL contention_count got %0d want 4", op_count); end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_backpressure;
    req0_valid = 1; req0_sel = 2'b01; req0_a = 3; req0_b = 5;
    req1_valid = 1;
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL bp_grant got r1r0=%b want 01", {req1_ready, req0_ready}); end
    tick();
    req0_sel = 2'b00; req0_a = 0; req0_b = 0; rsp0_ack = 1;
    tick();
    rsp0_ack = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (rsp0_valid !== 1'b1 || rsp0_data !== 6'd15 || {req0_ready, req1_ready} !== 2'b00 || op_count !== 8'd4) begin
        errors++; $display("FAIL bp_hold cyc%0d got v=%b d=%0d rdy=%b cnt=%0d want 1/15/00/4", i, rsp0_valid, rsp0_data, {req0_ready, req1_ready}, op_count);
      end
      tick();
    end
    rsp0_ack = 1;
    tick();
    rsp0_ack = 0; req0_valid = 0; req1_valid = 0;
    #1;
    vectors++;
    if (op_count !== 8'd5 || busy !== 1'b0) begin errors++; $display("FAIL bp_count got cnt=%0d busy=%b want 5/0", op_count, busy); end
    tick();
  endtask

  task automatic test_reset_mid;
    req1_valid = 1; req1_sel = 2'b01; req1_a = 6; req1_b = 3;
    tick();
    req1_valid = 0;
    tick();
    #1;
    vectors++;
    if (rsp1_valid !== 1'b1 || rsp1_data !== 6'd18) begin errors++; $display("FAIL rmid_pre got v=%b d=%0d want 1/18", rsp1_valid, rsp1_data); end
    do_reset();
    #1;
    vectors++;
    if ({rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready} !== 5'd0 || rsp1_data !== 6'd0 || op_count !== 8'd0) begin
      errors++; $display("FAIL rmid_clear got flags=%b d1=%0d cnt=%0d want 0", {rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready}, rsp1_data, op_count);
    end
    req0_valid = 1; req0_sel = 2'b00; req0_a = 7; req0_b = 7;
    req1_valid = 1;
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL rmid_grant got r1r0=%b want 01", {req1_ready, req0_ready}); end
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    #1;
    vectors++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 6'd7 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp got v0=%b d0=%0d v1=%b want 1/7/0", rsp0_valid, rsp0_data, rsp1_valid); end
    rsp0_ack = 1;
    tick();
    rsp0_ack = 0;
  endtask

  task automatic test_wrap;
    do_reset();
    req0_sel = 2'b11; req0_a = 1; req0_b = 1;
    for (int i = 0; i < 256; i++) begin
      req0_valid = 1;
      tick();
      req0_valid = 0;
      tick();
      rsp0_ack = 1;
      tick();
      rsp0_ack = 0;
      if (i == 254) begin
        vectors++;
        if (op_count !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", op_count); end
      end
    end
    #1;
    vectors++;
    if (op_count !== 8'd0) begin errors++; $display("FAIL wrap_0 got %0d want 0", op_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_opcodes();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/alu_share_ctrl.md
ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clk and rst SHALL be the port names.
REQ-002 The ports SHALL be as follows:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_sel  in  2  requester 0 opcode
- req0_a  in  3  requester 0 operand A
- req0_b  in  3  requester 0 operand B
- req0_ready  out  1  requester 0 transfer accepted this cycle
- rsp0_valid  out  1  requester 0 result available
- rsp0_data  out  6  requester 0 result
- rsp0_ack  in  1  requester 0 consumes result
- req1_valid, req1_sel, req1_a, req1_b, req1_ready, rsp1_valid, rsp1_data, rsp1_ack  same widths and meanings, for requester 1
- busy  out  1  high in any state other than IDLE
- op_count  out  8  number of completed responses

Function
REQ-003 The opcode SHALL give results as follows, all unsigned, zero-extended to 6 bits:
- 00: A AND B
- 01: A*B (full 6-bit product)
- 10: NAND in bits [2:0], with bits [5:3] equal to 0
- 11: A XOR B
REQ-004 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-005 In IDLE, req0_ready and req1_ready SHALL be combinational, and at most one SHALL be high: the winner among valid requesters under round-robin priority.
REQ-006 Round-robin priority SHALL work as follows:
- a priority pointer names the preferred requester;
- if both requesters are valid, the preferred one wins;
- if only one is valid, it wins regardless of the pointer.
REQ-007 A transfer SHALL occur when reqN_valid and reqN_ready are both high. At that edge the block SHALL:
- latch sel, a and b;
- record the grant index;
- go from IDLE to EXEC.
REQ-008 In EXEC, the block SHALL compute the REQ-003 result from the latched operands, register it, and go to RESP on the next edge; EXEC always lasts exactly one cycle.
REQ-009 In RESP, rspN_valid SHALL be high for the granted requester only, with rspN_data equal to the registered result held stable.
REQ-010 RESP SHALL persist until rspN_ack is high. On that edge the block SHALL:
- return to IDLE;
- set the priority pointer to the other requester;
- increment op_count.
REQ-011 Latency SHALL be: transfer at edge T, rspN_valid first high in the cycle after edge T+1; a result acked immediately frees the block for a new transfer two cycles after that.
REQ-012 An rspN_ack for the non-granted requester, or an ack outside RESP, SHALL be ignored.
REQ-013 reqN_ready SHALL be 0 in EXEC and RESP, so that no new transfers are accepted while busy.
REQ-014 A requester's valid may be dropped before it is granted; no transfer SHALL occur without a ready/valid overlap.
REQ-015 op_count SHALL wrap from 255 to 0.
REQ-016 rspN_data SHALL read 0 whenever rspN_valid is 0.
REQ-017 Input changes in EXEC or RESP SHALL NOT affect the latched operation.

Reset
REQ-018 When rst is high at a clock edge, the block SHALL:
- enter IDLE;
- set the priority pointer to requester 0;
- clear op_count, the result register and the latched operands;
- drive all ready and rsp outputs to 0 and busy to 0.
REQ-019 rst SHALL take effect from any state, including mid-EXEC and mid-RESP. An in-flight operation SHALL be discarded with no response, and op_count SHALL NOT be incremented.
REQ-020 In the first cycle after reset, a requester valid SHALL be granted per REQ-006 with requester 0 preferred.

Verification
REQ-021 Single op: req0 issues sel=01, a=7, b=7, with immediate ack -> rsp0_data=6'd49 two cycles after the transfer; op_count=1.
REQ-022 Opcode sweep: a=3'b101, b=3'b011 -> sel=00 gives 000001, sel=10 gives 000110, sel=11 gives 000110, sel=01 gives 001111.
REQ-023 Contention: both valid continuously after reset -> grants alternate 0,1,0,1; op_count=4 after four acks.
REQ-024 Backpressure: ack withheld for 5 cycles in RESP -> rsp valid and data held constant, ready low throughout, and a single op_count increment once ack arrives.
REQ-025 Reset mid-RESP: rst asserted while rsp1_valid=1 -> next cycle all outputs 0, op_count unchanged-to-0, pointer=0; req1 and req0 both valid -> req0 granted.
REQ-026 Wrap: 256 completed ops -> op_count returns to 0.
